plru_array: RTL



---
 rtl/plru_array.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/plru_array.sv
// plru_array: per-set tree pseudo-LRU replacement state for an N-way
// set-associative cache. Owns the MRU update and victim selection so the
// datapath only issues "touch way W of set S" and "which way to evict in set S".
//
// Ports:
//   clk0       clock
//   rst0       synchronous active-high reset
//   rd_csb     active-low lookup select; registers rd_addr / rd_valid
//   rd_addr    lookup set index
//   rd_valid   per-way valid bits of the looked-up set
//   rd_state   tree bits of the registered lookup set (forwarded if a touch
//              to the same set is in flight)
//   rd_victim  way to replace: lowest invalid way, else the tree victim
//   tc_csb     active-low touch select; registers tc_addr / tc_way
//   tc_addr    touched set index
//   tc_way     way to mark most-recently-used
//
// Tree bits are in heap order: node 0 is the root, node i has children
// 2i+1 and 2i+2. A node bit of 0 steers the victim walk to the lower-way
// subtree, 1 to the upper-way subtree.
module plru_array #(
    parameter int unsigned S_INDEX = 4,
    parameter int unsigned WAYS    = 4
) (
    input  logic                       clk0,
    input  logic                       rst0,
    input  logic                       rd_csb,
    input  logic [S_INDEX-1:0]         rd_addr,
    input  logic [WAYS-1:0]            rd_valid,
    output logic [WAYS-2:0]            rd_state,
    output logic [$clog2(WAYS)-1:0]    rd_victim,
    input  logic                       tc_csb,
    input  logic [S_INDEX-1:0]         tc_addr,
    input  logic [$clog2(WAYS)-1:0]    tc_way
);

    localparam int unsigned NUM_SETS = 2 ** S_INDEX;
    localparam int unsigned LOG_WAYS = $clog2(WAYS);
    localparam int unsigned WIDTH    = WAYS - 1;

    // Heap index of the node visited at a given tree level on the way's path.
    function automatic int path_node(input int level, input logic [LOG_WAYS-1:0] way);
        return ((1 << level) - 1) + (int'(32'(way)) >> (int'(LOG_WAYS) - level));
    endfunction

    // Way-index bit that selects the branch taken at a given tree level.
    function automatic logic way_bit(input int level, input logic [LOG_WAYS-1:0] way);
        return ((int'(32'(way)) >> (int'(LOG_WAYS) - 1 - level)) & 1) != 0;
    endfunction

    logic [WIDTH-1:0]    state_mem [NUM_SETS];

    logic [S_INDEX-1:0]  rd_addr_reg;
    logic [WAYS-1:0]     rd_valid_reg;

    logic                tc_pend;
    logic [S_INDEX-1:0]  tc_addr_reg;
    logic [LOG_WAYS-1:0] tc_way_reg;

    logic [WIDTH-1:0]    tc_old_state;
    logic [WIDTH-1:0]    tc_new_state;
    logic [WIDTH-1:0]    rd_eff_state;
    logic                fwd_hit;
    logic                inv_found;
    logic [LOG_WAYS-1:0] inv_way;
    logic [LOG_WAYS-1:0] tree_victim;

    // Lookup registers: capture set and valid mask on a selected edge.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            rd_addr_reg  <= '0;
            rd_valid_reg <= '1;
        end else if (!rd_csb) begin
            rd_addr_reg  <= rd_addr;
            rd_valid_reg <= rd_valid;
        end
    end

    // Touch registers: the pending flag marks a read-modify-write in flight.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            tc_pend     <= 1'b0;
            tc_addr_reg <= '0;
            tc_way_reg  <= '0;
        end else begin
            tc_pend <= !tc_csb;
            if (!tc_csb) begin
                tc_addr_reg <= tc_addr;
                tc_way_reg  <= tc_way;
            end
        end
    end

    // State array: write-back of the pending touch; reset discards it.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                state_mem[s] <= '0;
            end
        end else if (tc_pend) begin
            state_mem[tc_addr_reg] <= tc_new_state;
        end
    end

    // MRU update: every node on the touched way's path points away from it.
    always_comb begin
        tc_old_state = state_mem[tc_addr_reg];
        tc_new_state = tc_old_state;
        for (int l = 0; l < int'(LOG_WAYS); l++) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i == path_node(l, tc_way_reg)) begin
                    tc_new_state[i] = ~way_bit(l, tc_way_reg);
                end
            end
        end
    end

    // Same-set forwarding so a lookup never sees a stale state.
    always_comb begin
        fwd_hit      = tc_pend && (tc_addr_reg == rd_addr_reg);
        rd_eff_state = fwd_hit ? tc_new_state : state_mem[rd_addr_reg];
    end

    // Lowest-index invalid way; scanning downward leaves the lowest one.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!rd_valid_reg[w]) begin
                inv_found = 1'b1;
                inv_way   = LOG_WAYS'(w);
            end
        end
    end

    // Tree walk from the root; the leaf heap index minus WIDTH is the way.
    always_comb begin
        int  node_i;
        logic node_bit;
        node_i   = 0;
        node_bit = 1'b0;
        for (int l = 0; l < int'(LOG_WAYS); l++) begin
            node_bit = 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (i == node_i) begin
                    node_bit = rd_eff_state[i];
                end
            end
            node_i = 2 * node_i + 1 + (node_bit ? 1 : 0);
        end
        tree_victim = LOG_WAYS'(node_i - int'(WIDTH));
    end

    // Outputs.
    always_comb begin
        rd_state  = rd_eff_state;
        rd_victim = inv_found ? inv_way : tree_victim;
    end

endmodule
